serdes_rx_framer: RTL

- Receive-side deserializer and word aligner inside tt_um_serdes.
- Takes the raw serial bit stream from the pad input and hunts for a sync word to find word boundaries.
- Once aligned, presents parallel data words with a one-cycle valid strobe to the downstream parallel logic and uo_out.
- Reports lock status; the control logic can force realignment.

---
 rtl/serdes_rx_framer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/serdes_rx_framer.sv
// serdes_rx_framer
// Receive-side deserializer and word aligner. Shifts in the serial stream MSB
// first, hunts for SYNC_WORD to find the frame boundary, confirms it with
// LOCK_COUNT consecutive on-boundary sync frames, then delivers each non-sync
// word on data_out with a one-cycle data_valid strobe.
//
// Optional build macro SERDES_RX_PARITY_EN: frames grow to WIDTH+1 bits (data
// followed by an even-parity bit) and a parity_err strobe accompanies
// data_valid when a delivered frame has odd overall parity.
module serdes_rx_framer #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD  = 8'hBC,
    parameter int unsigned      LOCK_COUNT = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             serial_in,
    input  logic             realign,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             sync_det,
    output logic             locked,
    output logic [1:0]       state_out
`ifdef SERDES_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);

    // Frame geometry: the sync frame carries its own correct parity bit so the
    // hunt window and the per-frame compare both cover the whole frame.
`ifdef SERDES_RX_PARITY_EN
    localparam int unsigned     FLEN       = WIDTH + 1;
    localparam logic [FLEN-1:0] SYNC_FRAME = {SYNC_WORD, ^SYNC_WORD};
`else
    localparam int unsigned     FLEN       = WIDTH;
    localparam logic [FLEN-1:0] SYNC_FRAME = SYNC_WORD;
`endif

    localparam int unsigned     CW          = $clog2(FLEN);
    localparam logic [CW-1:0]   LAST_BIT    = CW'(FLEN - 1);
    localparam logic [3:0]      LOCK_TARGET = 4'(LOCK_COUNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state;
    logic [FLEN-1:0] sr;
    logic [CW-1:0]   bit_cnt;
    logic [3:0]      match_cnt;

    // One-frame holding stage between frame completion and the output strobe,
    // giving the one-edge delivery latency after the last bit is sampled.
    logic             pend_data;
    logic             pend_sync;
    logic [WIDTH-1:0] pend_word;
`ifdef SERDES_RX_PARITY_EN
    logic             pend_perr;
`endif

    // Frame as it will look after this edge's sample is shifted in; all
    // decisions on a sampled edge are made on this value.
    logic [FLEN-1:0] sr_next;
    logic            frame_done;
    logic            frame_is_sync;

    assign sr_next       = {sr[FLEN-2:0], serial_in};
    assign frame_done    = (bit_cnt == LAST_BIT);
    assign frame_is_sync = (sr_next == SYNC_FRAME);
    assign state_out     = state;

    // Serial sampling: shift in one bit per enabled cycle, frozen otherwise.
    // NOTE: clocked state is always assigned with <= so every register sees the
    // pre-edge value of every other register, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (ena) begin
            sr <= sr_next;
        end
    end

    // Alignment FSM, frame counters, holding stage and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            locked     <= 1'b0;
            bit_cnt    <= '0;
            match_cnt  <= '0;
            pend_data  <= 1'b0;
            pend_sync  <= 1'b0;
            pend_word  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            sync_det   <= 1'b0;
`ifdef SERDES_RX_PARITY_EN
            pend_perr  <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else if (realign) begin
            // Realign wins over sampling and delivery: anything completing or
            // waiting in the holding stage is dropped, data_out is kept.
            state      <= HUNT;
            locked     <= 1'b0;
            bit_cnt    <= '0;
            match_cnt  <= '0;
            pend_data  <= 1'b0;
            pend_sync  <= 1'b0;
            data_valid <= 1'b0;
            sync_det   <= 1'b0;
`ifdef SERDES_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (!ena) begin
            // Everything holds; the strobes must not stretch across idle cycles.
            data_valid <= 1'b0;
            sync_det   <= 1'b0;
`ifdef SERDES_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            // Release the frame captured on the previous sampled edge.
            data_valid <= pend_data;
            sync_det   <= pend_sync;
            if (pend_data) begin
                data_out <= pend_word;
            end
`ifdef SERDES_RX_PARITY_EN
            parity_err <= pend_data & pend_perr;
`endif
            pend_data <= 1'b0;
            pend_sync <= 1'b0;

            case (state)
                HUNT: begin
                    // Bit-by-bit search; a hit marks the next bit as frame bit 0.
                    bit_cnt <= '0;
                    if (frame_is_sync) begin
                        match_cnt <= 4'd1;
                        if (LOCK_COUNT == 1) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            state <= VERIFY;
                        end
                    end
                end

                VERIFY: begin
                    bit_cnt <= frame_done ? '0 : bit_cnt + CW'(1);
                    if (frame_done) begin
                        if (frame_is_sync) begin
                            match_cnt <= match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == LOCK_TARGET) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            // The failing frame is consumed, not re-searched.
                            state     <= HUNT;
                            match_cnt <= '0;
                        end
                    end
                end

                LOCKED: begin
                    bit_cnt <= frame_done ? '0 : bit_cnt + CW'(1);
                    if (frame_done) begin
                        if (frame_is_sync) begin
                            pend_sync <= 1'b1;
                        end else begin
                            pend_data <= 1'b1;
                            pend_word <= sr_next[FLEN-1 -: WIDTH];
`ifdef SERDES_RX_PARITY_EN
                            pend_perr <= ^sr_next;
`endif
                        end
                    end
                end

                default: begin
                    state     <= HUNT;
                    locked    <= 1'b0;
                    bit_cnt   <= '0;
                    match_cnt <= '0;
                end
            endcase
        end
    end

endmodule
